// File: rtl/comparador_pkg.sv
// ============================================================================
// Module      : comparador_pkg
// Description : Shared constants for the comparator family (FSM encoding,
//               pattern-count and error-counter width derivations).
// Revision    : 1.0
// ============================================================================
`default_nettype none

package comparador_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Exhaustive operand pairs for a WIDTH-bit comparator.
    function automatic int pattern_count(input int width);
        return 1 << (2 * width);
    endfunction

    // Wide enough to hold pattern_count(width) itself.
    function automatic int errw_for(input int width);
        return 2 * width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/contador_patrones.sv
// ============================================================================
// Module      : contador_patrones
// Description : PW-bit pattern counter with clear, increment and last flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module contador_patrones #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] pat,
    output logic          last
);

    localparam logic [PW-1:0] PAT_ONE = PW'(1);

    logic [PW-1:0] pat_q;
    logic [PW-1:0] pat_d;

    always_comb begin
        pat_d = pat_q;
        if (clr) begin
            pat_d = '0;
        end else if (inc) begin
            pat_d = pat_q + PAT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat  = pat_q;
    assign last = &pat_q;

endmodule

`default_nettype wire

// File: rtl/comparador_bist.sv
// ============================================================================
// Module      : comparador_bist
// Description : Exhaustive stimulus generator / checker for a WIDTH-bit
//               equality comparator. Optional COMPARADOR_BIST_STOP_EN stops
//               the run at the first mismatch.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module comparador_bist
    import comparador_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int SETTLE = 1,
    parameter int ERRW   = errw_for(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    output logic [WIDTH-1:0] i0,
    output logic [WIDTH-1:0] i1,
    input  logic             eq,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1);
    localparam logic [ERRW-1:0] ERR_ONE     = ERRW'(1);
    localparam logic [ERRW-1:0] ERR_MAX     = '1;

    logic [1:0]      state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic [PW-1:0]   pat;
    logic            pat_last;
    logic            pat_clr;
    logic            pat_inc;
    logic            mismatch;

    contador_patrones #(
        .PW (PW)
    ) u_contador (
        .clk  (clk),
        .rstn (rstn),
        .clr  (pat_clr),
        .inc  (pat_inc),
        .pat  (pat),
        .last (pat_last)
    );

    assign mismatch = (eq != (pat[PW-1:WIDTH] == pat[WIDTH-1:0]));

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        err_d    = err_q;
        pat_clr  = 1'b0;
        pat_inc  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pat_clr  = 1'b1;
                    err_d    = '0;
                    settle_d = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = CHECK;
                end else begin
                    settle_d = settle_q + SETTLE_ONE;
                end
            end
            CHECK: begin
                if (mismatch && (err_q != ERR_MAX)) begin
                    err_d = err_q + ERR_ONE;
                end
`ifdef COMPARADOR_BIST_STOP_EN
                if (mismatch || pat_last) begin
                    state_d = DONE;
                end else begin
                    pat_inc = 1'b1;
                    state_d = DRIVE;
                end
`else
                if (pat_last) begin
                    state_d = DONE;
                end else begin
                    pat_inc = 1'b1;
                    state_d = DRIVE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Status flags follow the next state so they are registered alongside it.
        busy_d = (state_d == DRIVE) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            settle_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign i0        = pat[PW-1:WIDTH];
    assign i1        = pat[WIDTH-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

`default_nettype wire

// File: tb/tb_comparador_bist.sv
// ============================================================================
// Module      : tb_comparador_bist
// Description : Self-checking bench for comparador_bist (WIDTH=2, SETTLE=3).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_comparador_bist;

    localparam int WIDTH  = 2;
    localparam int SETTLE = 3;
    localparam int ERRW   = 2 * WIDTH + 1;
    localparam int NPAT   = 1 << (2 * WIDTH);
    localparam int PER    = SETTLE + 1;

    logic             clk   = 1'b0;
    logic             rstn  = 1'b0;
    logic             start = 1'b0;
    logic             eq    = 1'b0;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERRW-1:0]  err_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    comparador_bist #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE),
        .ERRW   (ERRW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .i0        (i0),
        .i1        (i1),
        .eq        (eq),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // fault[p] set means the modelled comparator answers wrongly on pattern p.
    task automatic run(input string name, input logic [NPAT-1:0] fault, input bit poke_start);
        int exp_err  = 0;
        int stop_pat = NPAT - 1;
        int total;
        int p;
        for (int k = 0; k < NPAT; k++) begin
            if (fault[k]) begin
                exp_err++;
`ifdef COMPARADOR_BIST_STOP_EN
                stop_pat = k;
                break;
`endif
            end
        end
        if (exp_err > (1 << ERRW) - 1) exp_err = (1 << ERRW) - 1;
        total = (stop_pat + 1) * PER;

        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= total; c++) begin
            p = (c - 1) / PER;
            check({name, "/pattern"}, {i0, i1}, p);
            check({name, "/busy_done"}, {busy, done}, 2'b10);
            if (c % PER == 0) begin
                eq = (((p >> WIDTH) == (p % (1 << WIDTH))) ? 1'b1 : 1'b0) ^ fault[p];
            end else begin
                eq = 1'($urandom);
            end
            start = poke_start ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            check({name, "/done_busy_end"}, {busy, done}, 2'b01);
            check({name, "/err_count"}, err_count, exp_err);
            check({name, "/pass"}, pass, (exp_err == 0) ? 1 : 0);
            check({name, "/final_pattern"}, {i0, i1}, stop_pat);
            eq = 1'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [NPAT-1:0] m;

        repeat (2) @(negedge clk);
        check("reset/outputs", {busy, done, pass, i0, i1, err_count}, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle/outputs", {busy, done, pass, i0, i1, err_count}, 0);

        run("correct",  16'h0000, 1'b0);
        run("stuck0",   16'h8421, 1'b0);
        run("inverted", 16'hFFFF, 1'b0);
        run("single3",  16'h0008, 1'b1);

        // Abort during DRIVE of pattern 2.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 2 * PER + 2; c++) begin
            eq = 1'($urandom);
            @(negedge clk);
        end
        check("abort/in_pattern2", {busy, i0, i1}, {1'b1, 4'd2});
        rstn = 1'b0;
        #1;
        check("abort/async_reset", {busy, done, pass, i0, i1, err_count}, 0);
        @(negedge clk);
        check("abort/held_reset", {busy, done, pass, i0, i1, err_count}, 0);
        rstn = 1'b1;
        @(negedge clk);
        run("after_reset", 16'h0000, 1'b0);

        for (int t = 0; t < 4; t++) begin
            m = NPAT'($urandom);
            run($sformatf("rand%0d", t), m, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/comparador_bist.md
# comparador_bist

Sequential stimulus generator and checker for the comparator family: drives every input pair onto a WIDTH-bit equality comparator and samples its `eq` output. For each pair it compares `eq` against the expected `(i0 == i1)` and reports pass/fail plus an error count. It is the driving end of the comparator interface. It sits beside a comparator instance on the board as a hardware self-test, and also replaces open-ended stimulus in simulation.

## Interface
- `WIDTH`, 1: comparator operand width; 2^(2·WIDTH) patterns exhaustively applied.
- `SETTLE`, 1: cycles each pattern is held before `eq` is sampled; legal range ≥1.
- `ERRW`, 2·WIDTH+1: width of `err_count`; holds the max count 2^(2·WIDTH).

- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: run request; sampled in IDLE or DONE, ignored while busy.
- `i0` out WIDTH: operand A to comparator under test.
- `i1` out WIDTH: operand B to comparator under test.
- `eq` in 1: comparator result.
- `busy` out 1: high in DRIVE/CHECK.
- `done` out 1: high while in DONE.
- `pass` out 1: valid when `done`; 1 iff `err_count == 0`.
- `err_count` out ERRW: mismatches seen in current/last run, saturating.

## Operation
- Reset values: state IDLE; `i0`=0, `i1`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, pattern=0, settle counter=0.
- The pattern counter is 2·WIDTH bits wide. `i0` is its upper WIDTH bits; `i1` is its lower WIDTH bits. Patterns run from 0 upward.
- FSM states:
  - IDLE: on `start`, clear `err_count` and pattern, go to DRIVE.
  - DRIVE: hold the pattern; count SETTLE cycles, then go to CHECK.
  - CHECK: sample `eq` and compare it to `(i0 == i1)`. On mismatch, `err_count` += 1, saturating at all-ones. If pattern is the last one (all ones), go to DONE. Otherwise increment pattern and go to DRIVE.
  - DONE: `i0`/`i1` hold the last applied pattern. `start` restarts as from IDLE, clearing counters.
- `start` in DRIVE/CHECK has no effect. A held-high `start` restarts on the cycle after entering DONE.
- Reset mid-run aborts immediately to reset values. No partial result is kept.
- `eq` is treated as a synchronous input. No synchronizer is inside this block.

## Timing
- Per pattern: SETTLE cycles in DRIVE plus 1 cycle in CHECK.
- A run takes 2^(2·WIDTH)·(SETTLE+1) cycles.
- If `start` is sampled high at edge k:
  - `busy` rises after edge k.
  - `done` rises after edge k + 2^(2·WIDTH)·(SETTLE+1).
  - `busy` and `done` are never high together.
- `eq` is sampled at the edge that ends CHECK, SETTLE+1 edges after the pattern is applied.
- `err_count` and `pass` update the cycle after that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `COMPARADOR_BIST_STOP_EN`.
- Defined: the first mismatch in CHECK sends the FSM directly to DONE. `err_count` is 1, `pass`=0, and `i0`/`i1` hold the failing pattern.
- Undefined: all patterns run regardless of mismatches, and `err_count` totals them.

## Structure
- Shared package `comparador_pkg` holds:
  - state encoding constants IDLE/DRIVE/CHECK/DONE;
  - the pattern-count and ERRW derivation expressions, shared with comparator benches.
- One sub-module, `contador_patrones`: a 2·WIDTH-bit pattern counter with clear, increment and last-pattern flag.

## Test plan
- Correct comparator, WIDTH=1, SETTLE=1: pulse `start` → patterns 00,01,10,11 applied in order. `done` is high 8 cycles after start, with `pass`=1 and `err_count`=0.
- `eq` stuck at 0, WIDTH=1 → `err_count`=2 (patterns 00 and 11), `pass`=0. With `COMPARADOR_BIST_STOP_EN`: stops at pattern 00 with `err_count`=1 and `i0`=0, `i1`=0.
- Inverted comparator, WIDTH=2, SETTLE=3 → `done` after 64 cycles, `err_count`=16, `pass`=0.
- `start` pulsed again mid-run → no restart, and total run length is unchanged. `start` in DONE → counters cleared and a new run begins.
- `rstn` asserted during DRIVE of pattern 2 → all outputs return to reset values immediately. The next `start` runs from pattern 0.
- Mismatch injected only on pattern 3 with WIDTH=1 → `err_count`=1. An `eq` glitch outside CHECK cycles does not affect the count.
